// File: rtl/mcp3008_scanner_if.sv
// mcp3008_scanner_if
//   SPI link between the scanner (master) and the MCP3008 ADC (slave).
//   ad_clk : SCLK, idles low (mode 0,0)
//   cs     : chip select, active low
//   din    : MOSI, master -> ADC
//   dout   : MISO, ADC -> master (asynchronous to clk at the master)
interface mcp3008_scanner_if;
  logic ad_clk;
  logic cs;
  logic din;
  logic dout;

  modport master (output ad_clk, output cs, output din, input dout);
  modport slave  (input ad_clk, input cs, input din, output dout);
endinterface

// File: rtl/mcp3008_scanner.sv
// mcp3008_scanner
//   Autonomous SPI master that scans the channels selected by CH_MASK on an
//   MCP3008 in single-ended mode, keeps the latest 10-bit result per channel
//   in a bank, and strobes each completed conversion.
//
//   clk, rst_n       : system clock, asynchronous active-low reset
//   enable           : 1 = scanning allowed
//   spi              : SPI master side (ad_clk, cs, din out; dout in)
//   sample_data/_ch  : result and channel of the last conversion (held)
//   sample_valid     : 1-cycle strobe for a new result
//   sample_null_err  : null bit of the last conversion read back as 1
//   scan_done        : strobe with the last enabled channel of a scan
//   rd_ch / rd_data  : combinational read port into the result bank
//   busy             : 1 while not idle
module mcp3008_scanner #(
  parameter int unsigned SCLK_HALF      = 25,
  parameter int unsigned CS_HIGH_CYCLES = 50,
  parameter logic [7:0]  CH_MASK        = 8'hFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  mcp3008_scanner_if.master        spi,
  output logic [9:0]               sample_data,
  output logic [2:0]               sample_ch,
  output logic                     sample_valid,
  output logic                     sample_null_err,
  output logic                     scan_done,
  input  logic [2:0]               rd_ch,
  output logic [9:0]               rd_data,
  output logic                     busy
);

  localparam int unsigned CNT_MAX = (SCLK_HALF > CS_HIGH_CYCLES) ? SCLK_HALF : CS_HIGH_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_HIGH_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_END, S_GAP} state_t;

  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    lowest_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_ch = 3'(i);
    end
  endfunction

  // Nearest set bit above cur, wrapping; returns cur for a single-bit mask.
  function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [7:0] m);
    logic [2:0] idx;
    next_ch = cur;
    for (int i = 7; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (m[idx]) next_ch = idx;
    end
  endfunction

  // MOSI bit presented before rising edge k: start, SGL, then channel MSB first.
  function automatic logic din_for(input logic [4:0] k, input logic [2:0] ch);
    case (k)
      5'd1, 5'd2: din_for = 1'b1;
      5'd3:       din_for = ch[2];
      5'd4:       din_for = ch[1];
      5'd5:       din_for = ch[0];
      default:    din_for = 1'b0;
    endcase
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       k_q;
  logic             sck_q;
  logic             cs_q;
  logic             din_q;
  logic [2:0]       rise_q;
  logic             dout_s1_q;
  logic             dout_s2_q;
  logic             null_q;
  logic [9:0]       shreg_q;
  logic [2:0]       ptr_q;
  logic [9:0]       sample_data_q;
  logic [2:0]       sample_ch_q;
  logic             sample_valid_q;
  logic             sample_null_q;
  logic             scan_done_q;
  logic [9:0]       bank_q [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      k_q            <= '0;
      sck_q          <= 1'b0;
      cs_q           <= 1'b1;
      din_q          <= 1'b0;
      rise_q         <= '0;
      dout_s1_q      <= 1'b0;
      dout_s2_q      <= 1'b0;
      null_q         <= 1'b0;
      shreg_q        <= '0;
      ptr_q          <= lowest_ch(CH_MASK);
      sample_data_q  <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
      sample_null_q  <= 1'b0;
      scan_done_q    <= 1'b0;
      for (int i = 0; i < 8; i++) bank_q[i] <= '0;
    end else begin
      dout_s1_q      <= spi.dout;
      dout_s2_q      <= dout_s1_q;
      // rise_q[2] marks the cycle where the synchronised dout reflects the
      // line as it was when the SCLK rising edge was issued.
      rise_q         <= {rise_q[1:0], 1'b0};
      sample_valid_q <= 1'b0;
      scan_done_q    <= 1'b0;

      if (rise_q[2]) begin
        if (k_q == 5'd7) null_q <= dout_s2_q;
        else if (k_q >= 5'd8) shreg_q <= {shreg_q[8:0], dout_s2_q};
      end

      // Bank is updated one cycle after the strobe so readers see the old
      // value during the strobe cycle itself.
      if (sample_valid_q) bank_q[sample_ch_q] <= sample_data_q;

      case (state_q)
        S_IDLE: begin
          if (enable && (CH_MASK != 8'h00)) begin
            state_q <= S_SETUP;
            cs_q    <= 1'b0;
            din_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end

        S_SETUP: begin
          if (cnt_q == HALF_LAST) begin
            state_q   <= S_SHIFT;
            sck_q     <= 1'b1;
            k_q       <= 5'd1;
            rise_q[0] <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_SHIFT: begin
          if (cnt_q != HALF_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (sck_q) begin
              sck_q <= 1'b0;
              din_q <= din_for(k_q + 5'd1, ptr_q);
            end else if (k_q == 5'd17) begin
              state_q <= S_END;
            end else begin
              sck_q     <= 1'b1;
              k_q       <= k_q + 5'd1;
              rise_q[0] <= 1'b1;
            end
          end
        end

        S_END: begin
          cs_q           <= 1'b1;
          din_q          <= 1'b0;
          sample_valid_q <= 1'b1;
          sample_data_q  <= shreg_q;
          sample_ch_q    <= ptr_q;
          sample_null_q  <= null_q;
          scan_done_q    <= (next_ch(ptr_q, CH_MASK) <= ptr_q);
          state_q        <= S_GAP;
          cnt_q          <= '0;
        end

        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            ptr_q <= next_ch(ptr_q, CH_MASK);
            if (enable) begin
              state_q <= S_SETUP;
              cs_q    <= 1'b0;
              din_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign spi.ad_clk      = sck_q;
  assign spi.cs          = cs_q;
  assign spi.din         = din_q;
  assign sample_data     = sample_data_q;
  assign sample_ch       = sample_ch_q;
  assign sample_valid    = sample_valid_q;
  assign sample_null_err = sample_null_q;
  assign scan_done       = scan_done_q;
  assign rd_data         = bank_q[rd_ch];
  assign busy            = (state_q != S_IDLE);

endmodule
